// File: rtl/spi_e48_responder.sv
// SPI mode-0 target emulating the read side of a 25AA02E48 EUI-48 EEPROM.
// All SPI pins are synchronised into clk; READ streams MAC/FILL bytes, RDSR streams STATUS.
module spi_e48_responder #(
    parameter logic [47:0] MAC    = 48'h0004A3_000001,
    parameter logic [7:0]  FILL   = 8'hFF,
    parameter logic [7:0]  STATUS = 8'h00
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic e48_csl,
    input  logic e48_hold,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_STAT,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic       r_csl_s1, r_csl_s2;
    logic       r_hold_s1, r_hold_s2;
    logic       r_mosi_s1, r_mosi_s2;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [7:0] r_addr;

    logic       w_cs_active, w_edge_ok, w_active;
    logic       w_rise_en, w_fall_en, w_byte_done;
    logic [7:0] w_rx_byte, w_addr_inc;

    function automatic logic [7:0] f_byte(input logic [7:0] a);
        case (a)
            8'hFA:   return MAC[47:40];
            8'hFB:   return MAC[39:32];
            8'hFC:   return MAC[31:24];
            8'hFD:   return MAC[23:16];
            8'hFE:   return MAC[15:8];
            8'hFF:   return MAC[7:0];
            default: return FILL;
        endcase
    endfunction

    // Inactive levels on reset so no phantom CS or clock edge appears after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_csl_s1  <= 1'b1;
            r_csl_s2  <= 1'b1;
            r_hold_s1 <= 1'b1;
            r_hold_s2 <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage sample the previous stage's old value.
            r_sclk_s1 <= spi_clk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_csl_s1  <= e48_csl;
            r_csl_s2  <= r_csl_s1;
            r_hold_s1 <= e48_hold;
            r_hold_s2 <= r_hold_s1;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_cs_active = ~r_csl_s2;
    assign w_edge_ok   = w_cs_active & r_hold_s2;
    assign w_active    = (r_state == ST_CMD)  || (r_state == ST_ADDR) ||
                         (r_state == ST_DATA) || (r_state == ST_STAT);
    assign w_rise_en   = w_edge_ok & w_active & r_sclk_s2 & ~r_sclk_s3;
    assign w_fall_en   = w_edge_ok & w_active & ~r_sclk_s2 & r_sclk_s3;
    assign w_byte_done = w_rise_en & (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx_sr[6:0], r_mosi_s2};
    assign w_addr_inc  = r_addr + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        if (!w_cs_active) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD: if (w_byte_done) begin
                    if (w_rx_byte == CMD_READ)      w_state_nxt = ST_ADDR;
                    else if (w_rx_byte == CMD_RDSR) w_state_nxt = ST_STAT;
                    else                            w_state_nxt = ST_IGNORE;
                end
                ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Deasserting CS clears all per-transfer state so an aborted byte leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_rx_sr   <= 8'd0;
            r_tx_sr   <= 8'd0;
            r_addr    <= 8'd0;
            miso      <= 1'b0;
        end else if (!w_cs_active) begin
            r_bit_cnt <= 3'd0;
            r_rx_sr   <= 8'd0;
            r_tx_sr   <= 8'd0;
        end else if (w_rise_en) begin
            r_rx_sr   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
                case (r_state)
                    ST_CMD:  if (w_rx_byte == CMD_RDSR) r_tx_sr <= STATUS;
                    ST_ADDR: begin
                        r_addr  <= w_rx_byte;
                        r_tx_sr <= f_byte(w_rx_byte);
                    end
                    ST_DATA: begin
                        r_addr  <= w_addr_inc;
                        r_tx_sr <= f_byte(w_addr_inc);
                    end
                    ST_STAT: r_tx_sr <= STATUS;
                    default: r_tx_sr <= r_tx_sr;
                endcase
            end
        end else if (w_fall_en) begin
            miso    <= r_tx_sr[7];
            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
        end
    end

    assign miso_oe = w_edge_ok & ((r_state == ST_DATA) || (r_state == ST_STAT));
    assign busy    = (r_state != ST_IDLE) && (r_state != ST_IGNORE);

endmodule

// File: tb/tb_spi_e48_responder.sv
// Directed bench for spi_e48_responder: drives a mode-0 SPI host and checks the
// READ, RDSR, ignore, hold, abort and reset behaviour against hand-computed bytes.
module tb_spi_e48_responder;

    logic clk = 1'b0;
    logic reset;
    logic spi_clk, e48_csl, e48_hold, mosi;
    logic miso, miso_oe, busy;

    int n_tests = 0;
    int n_fail  = 0;

    spi_e48_responder dut (
        .clk      (clk),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .e48_csl  (e48_csl),
        .e48_hold (e48_hold),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One SPI bit: present mosi, wait half a period, sample miso, rise, wait, fall.
    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #40;
            rx[i] = miso;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_start();
        e48_csl = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #40;
        e48_csl = 1'b1;
        #100;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        spi_clk  = 1'b0;
        e48_csl  = 1'b1;
        e48_hold = 1'b1;
        mosi     = 1'b0;
        #20;
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", miso_oe); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++;
        if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
        reset = 1'b0;
        #100;
    endtask

    task automatic test_mac_read();
        logic [7:0] rx;
        logic [47:0] exp_mac;
        exp_mac = 48'h0004A3_000001;
        cs_start();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mac_busy_cmd got=%b exp=1", busy); end
        xfer_byte(8'h03, rx);
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL mac_oe_addr got=%b exp=0", miso_oe); end
        xfer_byte(8'hFA, rx);
        #40;
        n_tests++;
        if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL mac_oe_data got=%b exp=1", miso_oe); end
        for (int b = 0; b < 6; b++) begin
            xfer_byte(8'h00, rx);
            n_tests++;
            if (rx !== exp_mac[47 - 8*b -: 8]) begin
                n_fail++;
                $display("FAIL mac_byte%0d got=%h exp=%h", b, rx, exp_mac[47 - 8*b -: 8]);
            end
        end
        #40;
        e48_csl = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL mac_oe_cs_high got=%b exp=0", miso_oe); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mac_busy_cs_high got=%b exp=0", busy); end
        #99;
    endtask

    task automatic test_wrap();
        logic [7:0] rx;
        logic [7:0] exp_b [4];
        exp_b = '{8'h00, 8'h01, 8'hFF, 8'hFF};
        cs_start();
        xfer_byte(8'h03, rx);
        xfer_byte(8'hFE, rx);
        for (int b = 0; b < 4; b++) begin
            xfer_byte(8'h00, rx);
            n_tests++;
            if (rx !== exp_b[b]) begin n_fail++; $display("FAIL wrap_byte%0d got=%h exp=%h", b, rx, exp_b[b]); end
        end
        cs_end();
    endtask

    task automatic test_rdsr_ignore();
        logic [7:0] rx;
        cs_start();
        xfer_byte(8'h05, rx);
        #40;
        n_tests++;
        if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL rdsr_oe got=%b exp=1", miso_oe); end
        for (int b = 0; b < 3; b++) begin
            xfer_byte(8'h00, rx);
            n_tests++;
            if (rx !== 8'h00) begin n_fail++; $display("FAIL rdsr_byte%0d got=%h exp=00", b, rx); end
        end
        cs_end();

        cs_start();
        xfer_byte(8'h9F, rx);
        #40;
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL ignore_oe got=%b exp=0", miso_oe); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got=%b exp=0", busy); end
        xfer_byte(8'h03, rx);
        xfer_byte(8'hFA, rx);
        #40;
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL ignore_oe_late got=%b exp=0", miso_oe); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_late got=%b exp=0", busy); end
        cs_end();
    endtask

    task automatic test_hold();
        logic [7:0] rx;
        logic [4:0] rest;
        cs_start();
        xfer_byte(8'h03, rx);
        xfer_byte(8'hFA, rx);
        for (int i = 7; i >= 5; i--) begin
            mosi = 1'b0;
            #40;
            rx[i] = miso;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
        #40;
        e48_hold = 1'b0;
        #40;
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL hold_oe got=%b exp=0", miso_oe); end
        for (int t = 0; t < 2; t++) begin
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
            #40;
        end
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL hold_oe_toggling got=%b exp=0", miso_oe); end
        e48_hold = 1'b1;
        #40;
        n_tests++;
        if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL hold_oe_release got=%b exp=1", miso_oe); end
        for (int i = 4; i >= 0; i--) begin
            mosi = 1'b0;
            #40;
            rest[i] = miso;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
        n_tests++;
        if ({rx[7:5], rest} !== 8'h00) begin
            n_fail++;
            $display("FAIL hold_byte0 got=%h exp=00", {rx[7:5], rest});
        end
        xfer_byte(8'h00, rx);
        n_tests++;
        if (rx !== 8'h04) begin n_fail++; $display("FAIL hold_byte1 got=%h exp=04", rx); end
        cs_end();
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        cs_start();
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b0;
            #40;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
        cs_end();
        cs_start();
        xfer_byte(8'h03, rx);
        xfer_byte(8'hFB, rx);
        xfer_byte(8'h00, rx);
        n_tests++;
        if (rx !== 8'h04) begin n_fail++; $display("FAIL abort_byte0 got=%h exp=04", rx); end
        xfer_byte(8'h00, rx);
        n_tests++;
        if (rx !== 8'hA3) begin n_fail++; $display("FAIL abort_byte1 got=%h exp=a3", rx); end
        cs_end();
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] rx;
        cs_start();
        xfer_byte(8'h03, rx);
        xfer_byte(8'hFA, rx);
        xfer_byte(8'h00, rx);
        for (int i = 0; i < 3; i++) begin
            #40;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe got=%b exp=0", miso_oe); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        #19;
        reset = 1'b0;
        e48_csl = 1'b1;
        #100;
        cs_start();
        xfer_byte(8'h03, rx);
        xfer_byte(8'hFE, rx);
        xfer_byte(8'h00, rx);
        n_tests++;
        if (rx !== 8'h00) begin n_fail++; $display("FAIL rst_mid_fresh0 got=%h exp=00", rx); end
        xfer_byte(8'h00, rx);
        n_tests++;
        if (rx !== 8'h01) begin n_fail++; $display("FAIL rst_mid_fresh1 got=%h exp=01", rx); end
        cs_end();
    endtask

    initial begin
        reset = 1'b1;
        #10;
        test_reset();
        test_mac_read();
        test_wrap();
        test_rdsr_ignore();
        test_hold();
        test_abort();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_e48_responder.md
Name: spi_e48_responder

Overview:
SPI target that emulates the read side of the 25AA02E48 EUI-48 EEPROM. It answers the host-side SPI controller's chip-select/hold/clock sequence with EEPROM-compatible READ and RDSR responses, so the QeDebug CPLD can be exercised without a populated EEPROM. All SPI pins are oversampled and synchronised into the system clock domain; the MAC address is a parameter.

Parameters:
MAC, 48'h0004A3_000001, EUI-48 returned at addresses 0xFA..0xFF, MSB first; MAC[47:40] at 0xFA.
FILL, 8'hFF, byte returned for any address outside 0xFA..0xFF.
STATUS, 8'h00, byte returned repeatedly by RDSR.

Ports:
clk  in  1  system clock; must be at least 4x the spi_clk frequency.
reset  in  1  asynchronous, active-high.
spi_clk  in  1  SPI clock, mode 0 (idle low).
e48_csl  in  1  chip select, active low.
e48_hold  in  1  hold, active low; low pauses the transfer.
mosi  in  1  serial data from the controller.
miso  out  1  serial data to the controller.
miso_oe  out  1  output enable; miso is driven only when this is 1.
busy  out  1  high while a command is in progress (state is neither IDLE nor IGNORE).

Behaviour:
- Synchronisation: spi_clk, e48_csl, e48_hold and mosi each pass through a 2-FF synchroniser clocked by clk.
- Edge detection: a third spi_clk register gives rise = s2 & ~s3 and fall = ~s2 & s3.
- Edges count only while synced e48_csl = 0 and synced e48_hold = 1.
- Reset values: state IDLE, bit counter 0, shift registers 0, address 0; miso = 0, miso_oe = 0, busy = 0.
- Rising edge: sample synced mosi into the input shift register (MSB first) and increment the 3-bit bit counter.
- Falling edge: shift the output register left by one; miso = its MSB, registered.
- CS high at any time: state goes to IDLE, bit counter to 0, miso_oe to 0, all within 1 clk after the synchronised edge. A transfer aborted mid-byte leaves no residue.
- CS low: while CS is low and state is DATA or STAT, miso_oe = 1.
- Hold low: miso_oe = 0 and edges are ignored. State, counter and shift registers are frozen. On hold release, the transfer continues at the same bit.
- State CMD (entered on the CS falling edge from IDLE): after 8 rising edges, decode the received byte:
  - 0x03 goes to ADDR.
  - 0x05 loads STATUS into the output register and goes to STAT.
  - Any other value goes to IGNORE.
- State ADDR: after 8 rising edges, latch the address byte, load byte(addr) into the output register and go to DATA.
- State DATA:
  - After each 8th rising edge, address = address + 1 (8-bit, 0xFF wraps to 0x00) and byte(new addr) is loaded for the next falling edge.
  - byte(a) = MAC slice for 0xFA..0xFF, FILL otherwise.
  - The stream is unbounded until CS goes high.
- State STAT: STATUS is reloaded every 8 bits; the state persists until CS goes high.
- State IGNORE: miso_oe = 0 and all edges are discarded until CS goes high. Write commands (0x02, 0x06) land here, since the part is read-only.
- First output bit timing: the first data bit appears on miso after the falling edge that follows the 8th address (or command) rising edge. This matches 25AA02E48 mode-0 timing.
- Latency: each SPI edge is acted on 3 clk after the pin toggles.
- Simultaneous rise and CS deassert in the same clk: CS wins and the edge is dropped.
- Simultaneous hold low and an edge: hold wins.

Test Plan:
- Reset asserted mid-DATA with CS low -> miso_oe = 0, busy = 0 immediately. After release, the next CS cycle must begin with a fresh command.
- CS low, send 0x03, 0xFA, then clock 48 bits -> miso returns 0004A3000001 MSB first, miso_oe = 1 only during the data phase, CS high -> miso_oe = 0 within 4 clk.
- READ at 0xFE, clock 4 bytes -> 0x00, 0x01, 0xFF, 0xFF (0xFF wraps to 0x00, which returns FILL).
- RDSR 0x05, clock 3 bytes -> 0x00 three times. Unknown command 0x9F -> miso_oe stays 0 and busy = 0 for the rest of the CS cycle.
- READ 0xFA, hold low after bit 3 of the first data byte for 20 clk while toggling spi_clk -> miso_oe = 0 during hold, and after release the remaining bits are 0_0000 (byte 0x00 intact).
- CS high after 5 command bits, then a new CS cycle with 0x03, 0xFB -> the first data byte is 0x04, with no stale bits.
